// File: rtl/led_sched_pkg.sv
// Shared constants for the LED pattern scheduler: FSM state encoding and the
// bit-rate divider for the 16.63 MHz internal oscillator setting.
package led_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // 16.63 MHz / 2078750 gives roughly 8 pattern bits per second.
  localparam int DEFAULT_TICK_DIV = 2078750;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts at last_grant+1 and wraps,
// so the requester served most recently has the lowest priority.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [IW-1:0]   winner,
  output logic            any
);

  logic [IW:0] idx;

  always_comb begin
    winner = '0;
    idx    = '0;
    any    = |req;
    // Walk from the farthest offset to the nearest so the nearest valid requester wins.
    for (int k = NREQ; k >= 1; k--) begin
      idx = {1'b0, last_grant} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
      if (req[idx[IW-1:0]]) winner = idx[IW-1:0];
    end
  end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Round-robin scheduler that plays one requester's blink pattern at a time on
// the shared LED pin, MSB first, followed by a forced-low gap.
module led_pattern_scheduler
  import led_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int PAT_W     = 8,
  parameter int TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int GAP_TICKS = 2,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*PAT_W-1:0] req_pattern,
  output logic [NREQ-1:0]       req_ready,
  output logic                  pin_out,
  output logic                  busy,
  output logic [IW-1:0]         grant_id,
  output logic                  done,
  output logic [1:0]            state
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CMAX = (PAT_W > GAP_TICKS) ? PAT_W : GAP_TICKS;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(PAT_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  // Handshake: a pattern transfers on the single GRANT cycle in which
  // req_ready[grant_id] and req_valid[grant_id] are both high; valid may drop at any time before that.
  logic [IW-1:0]    last_grant, last_n, grant_n, arb_winner;
  logic             arb_any, tick_wrap, pin_n, busy_n, done_n;
  logic [1:0]       state_n;
  logic [PAT_W-1:0] shreg, shreg_n;
  logic [TW-1:0]    tick, tick_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [NREQ-1:0]  ready_n;
  logic [PAT_W-1:0] pats [NREQ];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner     (arb_winner),
    .any        (arb_any)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) pats[i] = req_pattern[i*PAT_W +: PAT_W];
  end

  always_comb begin
    state_n   = state;
    grant_n   = grant_id;
    last_n    = last_grant;
    shreg_n   = shreg;
    tick_n    = tick;
    cnt_n     = cnt;
    tick_wrap = (tick == TICK_LAST);
    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          grant_n = arb_winner;
          state_n = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (req_valid[grant_id]) begin
          shreg_n = pats[grant_id];
          last_n  = grant_id;
          tick_n  = '0;
          cnt_n   = '0;
          state_n = ST_PLAY;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_PLAY: begin
        tick_n = tick_wrap ? '0 : tick + 1'b1;
        if (tick_wrap) begin
          shreg_n = {shreg[PAT_W-2:0], 1'b0};
          cnt_n   = cnt + 1'b1;
          if (cnt == BIT_LAST) begin
            cnt_n   = '0;
            state_n = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
          end
        end
      end
      default: begin
        tick_n = tick_wrap ? '0 : tick + 1'b1;
        if (tick_wrap) begin
          cnt_n = cnt + 1'b1;
          if (cnt == GAP_LAST) begin
            cnt_n   = '0;
            state_n = ST_IDLE;
          end
        end
      end
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    ready_n = '0;
    if (state_n == ST_GRANT) ready_n[grant_n] = 1'b1;
    pin_n  = (state_n == ST_PLAY) && shreg_n[PAT_W-1];
    busy_n = (state_n != ST_IDLE);
    done_n = (tick_n == TICK_LAST) &&
             (((GAP_TICKS == 0) && (state_n == ST_PLAY) && (cnt_n == BIT_LAST)) ||
              ((GAP_TICKS != 0) && (state_n == ST_GAP)  && (cnt_n == GAP_LAST)));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      grant_id   <= '0;
      last_grant <= IW'(NREQ - 1);
      shreg      <= '0;
      tick       <= '0;
      cnt        <= '0;
      req_ready  <= '0;
      pin_out    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      grant_id   <= grant_n;
      last_grant <= last_n;
      shreg      <= shreg_n;
      tick       <= tick_n;
      cnt        <= cnt_n;
      req_ready  <= ready_n;
      pin_out    <= pin_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Bench for led_pattern_scheduler: a gapped instance (GAP_TICKS=2) and a
// gapless instance (GAP_TICKS=0), both with TICK_DIV=4 so a pattern plays in 32 cycles.
module tb_led_pattern_scheduler;
  import led_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int PAT_W = 8;
  localparam int TDIV = 4;

  logic        clk = 1'b0;
  logic        resetn, resetn0;
  logic [3:0]  req_valid, req_valid0;
  logic [31:0] req_pattern, req_pattern0;
  logic [3:0]  req_ready, req_ready0;
  logic        pin_out, pin_out0, busy, busy0, done, done0;
  logic [1:0]  grant_id, grant_id0, state, state0;

  led_pattern_scheduler #(.NREQ(NREQ), .PAT_W(PAT_W), .TICK_DIV(TDIV), .GAP_TICKS(2)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_pattern(req_pattern),
    .req_ready(req_ready), .pin_out(pin_out), .busy(busy), .grant_id(grant_id),
    .done(done), .state(state)
  );

  led_pattern_scheduler #(.NREQ(NREQ), .PAT_W(PAT_W), .TICK_DIV(TDIV), .GAP_TICKS(0)) dut0 (
    .clk(clk), .resetn(resetn0), .req_valid(req_valid0), .req_pattern(req_pattern0),
    .req_ready(req_ready0), .pin_out(pin_out0), .busy(busy0), .grant_id(grant_id0),
    .done(done0), .state(state0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [7:0] pat;
    logic [1:0] exp_id;
  } vec_t;

  vec_t       vecs [8];
  logic [9:0] exp_q [$];
  int         n_vec = 0;
  int         n_miss = 0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at the negedge where GRANT is visible; follows the pattern through PLAY and GAP.
  task automatic play_one(input logic [3:0] drop_mask, input string tag);
    logic [9:0] e;
    logic [1:0] id;
    logic [7:0] pat, got;
    logic       exp_pin;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_scoreboard: got empty queue, expected an entry", tag);
      return;
    end
    e   = exp_q.pop_front();
    id  = e[9:8];
    pat = e[7:0];
    got = '0;
    check({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << id));
    check({tag, "_grant"}, 32'(grant_id), 32'(id));
    check({tag, "_state_grant"}, 32'(state), 32'(ST_GRANT));
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 0) req_valid = req_valid & ~drop_mask;
      exp_pin = (i < 32) ? pat[7 - i/TDIV] : 1'b0;
      check($sformatf("%s_pin%0d", tag, i), 32'(pin_out), 32'(exp_pin));
      check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s_done%0d", tag, i), 32'(done), 32'(i == 39));
      check($sformatf("%s_noready%0d", tag, i), 32'(req_ready), 32'd0);
      if (i < 32 && (i % TDIV) == 2) got = {got[6:0], pin_out};
    end
    check({tag, "_pattern"}, 32'(got), 32'(pat));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_state"}, 32'(state), 32'(ST_IDLE));
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_pin"}, 32'(pin_out), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [7:0] lanes [4];
    logic       exp_pin;

    vecs[0] = '{4'b0001, 8'hA3, 2'd0};
    vecs[1] = '{4'b1111, 8'h00, 2'd1};
    vecs[2] = '{4'b0101, 8'h5C, 2'd2};
    vecs[3] = '{4'b1001, 8'h81, 2'd3};
    vecs[4] = '{4'b0110, 8'h7E, 2'd1};
    vecs[5] = '{4'b0001, 8'hC3, 2'd0};
    vecs[6] = '{4'b1100, 8'h01, 2'd2};
    vecs[7] = '{4'b0001, 8'h3C, 2'd0};

    resetn = 1'b0; resetn0 = 1'b0;
    req_valid = '0; req_valid0 = '0;
    req_pattern = '0; req_pattern0 = '0;
    step(); step();
    check("rst_pin", 32'(pin_out), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst0_pin", 32'(pin_out0), 32'd0);
    check("rst0_busy", 32'(busy0), 32'd0);
    resetn = 1'b1; resetn0 = 1'b1;
    step();
    check_idle("post_rst");

    // Single requests through the round-robin pointer; the winning lane holds pat, the others ~pat.
    for (int v = 0; v < 8; v++) begin
      for (int l = 0; l < 4; l++)
        req_pattern[l*8 +: 8] = (l == int'(vecs[v].exp_id)) ? vecs[v].pat : ~vecs[v].pat;
      req_valid = vecs[v].valid;
      exp_q.push_back({vecs[v].exp_id, vecs[v].pat});
      step();
      play_one(4'b1111, $sformatf("vec%0d", v));
      step();
      check_idle($sformatf("vec%0d", v));
    end

    // Requester 2 withdraws in GRANT while 1 and 3 arrive; last_grant is still 0, so 1 wins.
    req_pattern = {8'h42, 8'hE7, 8'h96, 8'h18};
    req_valid = 4'b0100;
    step();
    check("wd_ready", 32'(req_ready), 32'b0100);
    check("wd_grant", 32'(grant_id), 32'd2);
    req_valid = 4'b1010;
    step();
    check_idle("wd");
    check("wd_noready", 32'(req_ready), 32'd0);
    exp_q.push_back({2'd1, 8'h96});
    step();
    play_one(4'b1111, "wd_next");
    step();
    check_idle("wd_next");

    // Reset at bit 3 of an all-ones pattern.
    req_pattern = {8'h00, 8'h00, 8'h00, 8'hFF};
    req_valid = 4'b0001;
    step();
    check("rp_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    check("rp_pin0", 32'(pin_out), 32'd1);
    for (int i = 1; i <= 3*TDIV; i++) begin
      step();
      check($sformatf("rp_pin%0d", i), 32'(pin_out), 32'd1);
    end
    check("rp_state_play", 32'(state), 32'(ST_PLAY));
    resetn = 1'b0;
    #1;
    check("rp_async_pin", 32'(pin_out), 32'd0);
    check("rp_async_busy", 32'(busy), 32'd0);
    check("rp_async_state", 32'(state), 32'(ST_IDLE));
    step();
    check("rp_held_pin", 32'(pin_out), 32'd0);
    resetn = 1'b1;

    // All four held valid after reset: grants 0,1,2,3,0 with IDLE+GRANT between patterns.
    req_pattern = {8'h0F, 8'h69, 8'hC5, 8'h3A};
    req_valid = 4'b1111;
    exp_q.push_back({2'd0, 8'h3A});
    exp_q.push_back({2'd1, 8'hC5});
    exp_q.push_back({2'd2, 8'h69});
    exp_q.push_back({2'd3, 8'h0F});
    exp_q.push_back({2'd0, 8'h3A});
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        step();
        check_idle($sformatf("rr%0d", k));
      end
      step();
      play_one((k == 4) ? 4'b1111 : 4'b0000, $sformatf("rr%0d", k));
    end
    step();
    check_idle("rr_end");

    // Gapless instance with 8'hFF held: 32 high, IDLE and GRANT low, 32 high.
    req_pattern0 = {8'h00, 8'h00, 8'h00, 8'hFF};
    req_valid0 = 4'b0001;
    step();
    check("ng_ready", 32'(req_ready0), 32'b0001);
    for (int i = 0; i < 66; i++) begin
      step();
      exp_pin = (i < 32) || (i >= 34);
      check($sformatf("ng_pin%0d", i), 32'(pin_out0), 32'(exp_pin));
      check($sformatf("ng_done%0d", i), 32'(done0), 32'((i == 31) || (i == 65)));
      if (i == 33) begin
        check("ng_regrant_ready", 32'(req_ready0), 32'b0001);
        check("ng_regrant_state", 32'(state0), 32'(ST_GRANT));
      end
    end
    req_valid0 = '0;
    step();
    check("ng_end_busy", 32'(busy0), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
